// File: rtl/mmap_read_stream.sv
// rtl/mmap_read_stream.sv - command-driven read front end for async_mmap: expands {len, base} into beat addresses and forwards beats with last.
// Optional MMAP_READ_STREAM_STATS_EN adds stat_beats / stat_stall counters.
module mmap_read_stream #(
  parameter int AddrWidth         = 64,
  parameter int DataWidth         = 512,
  parameter int DataWidthBytesLog = 6,
  parameter int LenWidth          = 32,
  parameter int MaxOutstanding    = 64,
  parameter int OutstandingLog    = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [LenWidth+AddrWidth-1:0] cmd_din,
  input  logic                          cmd_write,
  output logic                          cmd_full_n,
  output logic [AddrWidth-1:0]          read_addr_din,
  output logic                          read_addr_write,
  input  logic                          read_addr_full_n,
  input  logic [DataWidth-1:0]          read_data_dout,
  output logic                          read_data_read,
  input  logic                          read_data_empty_n,
  output logic [DataWidth:0]            data_dout,
  output logic                          data_write,
  input  logic                          data_full_n,
  output logic                          busy
`ifdef MMAP_READ_STREAM_STATS_EN
  ,
  output logic [31:0]                   stat_beats,
  output logic [31:0]                   stat_stall
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [AddrWidth-1:0] AlignMask =
    ~((AddrWidth'(1) << DataWidthBytesLog) - AddrWidth'(1));
  localparam logic [OutstandingLog-1:0] MaxOut = OutstandingLog'(MaxOutstanding);

  state_t                    state, state_next;
  logic [AddrWidth-1:0]      base;
  logic [LenWidth-1:0]       len, issued, recv;
  logic [OutstandingLog-1:0] outstanding;
  logic [LenWidth-1:0]       cmd_len;
  logic                      push, fwd, last_beat;

  assign cmd_len = cmd_din[LenWidth+AddrWidth-1:AddrWidth];

  always_comb begin
    state_next    = state;
    cmd_full_n    = 1'b0;
    push          = 1'b0;
    fwd           = 1'b0;
    read_addr_din = '0;
    data_dout     = '0;
    last_beat     = (recv == len - LenWidth'(1));
    case (state)
      IDLE: begin
        cmd_full_n = 1'b1;
        if (cmd_write && cmd_len != '0) state_next = ISSUE;
      end
      ISSUE: begin
        push          = read_addr_full_n && (outstanding < MaxOut);
        read_addr_din = base + (AddrWidth'(issued) << DataWidthBytesLog);
        fwd           = read_data_empty_n && data_full_n;
        data_dout     = {last_beat, read_data_dout};
        if (fwd && last_beat) state_next = IDLE;
        else if (push && (issued + LenWidth'(1) == len)) state_next = DRAIN;
      end
      DRAIN: begin
        fwd       = read_data_empty_n && data_full_n;
        data_dout = {last_beat, read_data_dout};
        if (fwd && last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign read_addr_write = push;
  assign read_data_read  = fwd;
  assign data_write      = fwd;
  assign busy            = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      base        <= '0;
      len         <= '0;
      issued      <= '0;
      recv        <= '0;
      outstanding <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && cmd_write) begin
        // Base is beat-aligned so every issued address is a whole-beat address.
        base        <= cmd_din[AddrWidth-1:0] & AlignMask;
        len         <= cmd_len;
        issued      <= '0;
        recv        <= '0;
        outstanding <= '0;
      end else begin
        if (push) issued <= issued + LenWidth'(1);
        if (fwd)  recv   <= recv + LenWidth'(1);
        case ({push, fwd})
          2'b10:   outstanding <= outstanding + OutstandingLog'(1);
          2'b01:   outstanding <= outstanding - OutstandingLog'(1);
          default: ;
        endcase
      end
    end
  end

`ifdef MMAP_READ_STREAM_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      if (fwd) stat_beats <= stat_beats + 32'd1;
      if (state == ISSUE && !push) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mmap_read_stream.sv
// tb/tb_mmap_read_stream.sv - self-checking bench for mmap_read_stream with a 1-cycle-latency memory model.
module tb_mmap_read_stream;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [95:0]  cmd_din = '0;
  logic         cmd_write = 1'b0;
  logic         cmd_full_n;
  logic [63:0]  read_addr_din;
  logic         read_addr_write;
  logic         read_addr_full_n = 1'b1;
  logic [511:0] read_data_dout = '0;
  logic         read_data_read;
  logic         read_data_empty_n = 1'b0;
  logic [512:0] data_dout;
  logic         data_write;
  logic         data_full_n = 1'b1;
  logic         busy;

  mmap_read_stream dut (
    .clk(clk), .rst_n(rst_n), .cmd_din(cmd_din), .cmd_write(cmd_write),
    .cmd_full_n(cmd_full_n), .read_addr_din(read_addr_din),
    .read_addr_write(read_addr_write), .read_addr_full_n(read_addr_full_n),
    .read_data_dout(read_data_dout), .read_data_read(read_data_read),
    .read_data_empty_n(read_data_empty_n), .data_dout(data_dout),
    .data_write(data_write), .data_full_n(data_full_n), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] len;
    logic [63:0] base;
    logic [63:0] a0;
    logic [63:0] alast;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0]  addr_log[$];
  int           addr_cyc[$];
  logic [512:0] beat_log[$];
  logic [63:0]  mem[$];
  logic         push_s = 1'b0, pop_s = 1'b0, rst_s = 1'b0;
  logic [63:0]  addr_s = '0;

  function automatic logic [511:0] pat(input logic [63:0] a);
    return {8{a ^ 64'hC3C3_0000_0000_0000}};
  endfunction

  task automatic chk(input string name, input logic [512:0] act, input logic [512:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are sampled mid-cycle; the memory acts on them just after the next edge.
  always @(negedge clk) begin
    push_s = read_addr_write;
    pop_s  = read_data_read;
    rst_s  = rst_n;
    addr_s = read_addr_din;
    if (read_addr_write) begin
      addr_log.push_back(read_addr_din);
      addr_cyc.push_back(cyc);
    end
    if (data_write) beat_log.push_back(data_dout);
  end

  always @(posedge clk) begin
    #1;
    if (!rst_s) mem.delete();
    else begin
      if (pop_s && mem.size() > 0) void'(mem.pop_front());
      if (push_s) mem.push_back(addr_s);
    end
    read_data_empty_n = (mem.size() > 0);
    read_data_dout    = (mem.size() > 0) ? pat(mem[0]) : '0;
  end

  task automatic clear_logs();
    addr_log.delete();
    addr_cyc.delete();
    beat_log.delete();
  endtask

  task automatic send_cmd(input logic [31:0] l, input logic [63:0] b, output int acc);
    @(posedge clk); #1;
    cmd_din   = {l, b};
    cmd_write = 1'b1;
    @(posedge clk); #1;
    cmd_write = 1'b0;
    acc       = cyc;
  endtask

  task automatic wait_idle(input int bound, output int idle_cyc);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk); #1;
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
    idle_cyc = cyc;
  endtask

  function automatic int last_count();
    int c = 0;
    foreach (beat_log[i]) if (beat_log[i][512]) c++;
    return c;
  endfunction

  vec_t vecs[5];

  initial begin
    int acc, idle_c, n;
    logic [63:0] ea;

    vecs[0] = '{32'd4, 64'h1000, 64'h1000, 64'h10C0};
    vecs[1] = '{32'd0, 64'h2000, 64'h0, 64'h0};
    vecs[2] = '{32'd2, 64'h1007, 64'h1000, 64'h1040};
    vecs[3] = '{32'd2, 64'hFFFF_FFFF_FFFF_FFC0, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0};
    vecs[4] = '{32'd1, 64'h3000, 64'h3000, 64'h3000};

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_cmd_full_n", cmd_full_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr_write", read_addr_write, 1'b0);
    chk("rst_data_read", read_data_read, 1'b0);
    chk("rst_data_write", data_write, 1'b0);
    chk("rst_data_dout", data_dout, '0);
    chk("rst_addr_din", read_addr_din, '0);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      clear_logs();
      send_cmd(vecs[v].len, vecs[v].base, acc);
      @(negedge clk); #1;
      chk("busy_after_cmd", busy, vecs[v].len != 0);
      chk("cmd_full_n_after_cmd", cmd_full_n, vecs[v].len == 0);
      wait_idle(500, idle_c);
      chk("addr_count", addr_log.size(), vecs[v].len);
      chk("beat_count", beat_log.size(), vecs[v].len);
      chk("last_count", last_count(), (vecs[v].len != 0) ? 1 : 0);
      if (vecs[v].len != 0 && addr_log.size() == int'(vecs[v].len)) begin
        chk("first_addr", addr_log[0], vecs[v].a0);
        chk("last_addr", addr_log[addr_log.size()-1], vecs[v].alast);
        chk("first_addr_cycle", addr_cyc[0], acc);
        chk("addr_span", addr_cyc[addr_cyc.size()-1] - addr_cyc[0], vecs[v].len - 1);
        chk("idle_cycle", idle_c, acc + int'(vecs[v].len) + 1);
        for (int i = 0; i < addr_log.size(); i++) begin
          ea = vecs[v].a0 + (64'(i) << 6);
          chk("addr_stride", addr_log[i], ea);
          if (i < beat_log.size())
            chk("beat_data", beat_log[i], {i == int'(vecs[v].len) - 1, pat(ea)});
        end
      end
    end

    // Outstanding limit: user stream blocked, only 64 addresses may go out.
    clear_logs();
    data_full_n = 1'b0;
    send_cmd(32'd200, 64'h4000, acc);
    repeat (100) @(negedge clk);
    #1;
    chk("hold_addr_count", addr_log.size(), 64);
    chk("hold_addr_write", read_addr_write, 1'b0);
    chk("hold_beat_count", beat_log.size(), 0);
    @(posedge clk); #1;
    data_full_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("resume_beats", beat_log.size(), 10);
    chk("resume_addrs", addr_log.size(), 73);
    wait_idle(1000, idle_c);
    chk("big_addr_count", addr_log.size(), 200);
    chk("big_beat_count", beat_log.size(), 200);
    chk("big_last_count", last_count(), 1);
    if (beat_log.size() == 200)
      chk("big_last_beat", beat_log[199], {1'b1, pat(64'h4000 + 64'd199 * 64'd64)});

    // Reset in the middle of an 8-beat command.
    clear_logs();
    send_cmd(32'd8, 64'h8000, acc);
    n = 0;
    while (beat_log.size() < 3 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("three_beats_seen", beat_log.size() >= 3, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("mid_rst_cmd_full_n", cmd_full_n, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_addr_write", read_addr_write, 1'b0);
    chk("mid_rst_data_read", read_data_read, 1'b0);
    chk("mid_rst_data_write", data_write, 1'b0);
    chk("mid_rst_data_dout", data_dout, '0);
    chk("mid_rst_addr_din", read_addr_din, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_logs();
    send_cmd(32'd1, 64'h9000, acc);
    @(negedge clk); #1;
    wait_idle(100, idle_c);
    chk("post_rst_addr_count", addr_log.size(), 1);
    chk("post_rst_beat_count", beat_log.size(), 1);
    if (beat_log.size() == 1)
      chk("post_rst_beat", beat_log[0], {1'b1, pat(64'h9000)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
